xor_stream_cipher: RTL and testbench

Parametrised streaming XOR cipher engine, the next-generation datapath core of the XOR cipher top. It replaces the fixed 32-bit-key / 512-bit-message buffer-then-encrypt flow with LANE_WIDTH-bit beats under valid/ready handshakes. The key is loaded once and repeated cyclically over messages of any length up to MAX_MSG_BITS. It sits between the pin-level deserialiser front end and the serialiser back end.

---
 rtl/xor_stream_cipher_pkg.sv | 25 ++
 rtl/xor_stream_cipher_if.sv | 31 +++
 rtl/xor_key_store.sv | 54 +++++
 rtl/xor_stream_cipher.sv | 128 ++++++++++++
 tb/tb_xor_stream_cipher.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_stream_cipher_pkg.sv
// Shared types and sizing helpers for the streaming XOR cipher.
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_KEY,
        STREAM
    } state_t;

    localparam int unsigned DEF_KEY_WIDTH    = 32;
    localparam int unsigned DEF_LANE_WIDTH   = 8;
    localparam int unsigned DEF_MAX_MSG_BITS = 512;

    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned beats(input int unsigned total, input int unsigned lane);
        return total / lane;
    endfunction

    localparam int unsigned KEY_BEATS = beats(DEF_KEY_WIDTH, DEF_LANE_WIDTH);
    localparam int unsigned MSG_BEATS = beats(DEF_MAX_MSG_BITS, DEF_LANE_WIDTH);

endpackage

// File: rtl/xor_stream_cipher_if.sv
// Key-load, plaintext and ciphertext handshakes of the streaming XOR cipher.
interface xor_stream_cipher_if #(
    parameter int unsigned LANE_WIDTH = 8
);
    logic                  iEn;
    logic                  iLoad_key;
    logic [LANE_WIDTH-1:0] iKey_data;
    logic                  iKey_valid;
    logic                  oKey_ready;
    logic [LANE_WIDTH-1:0] iMsg_data;
    logic                  iMsg_valid;
    logic                  iMsg_last;
    logic                  oMsg_ready;
    logic [LANE_WIDTH-1:0] oData;
    logic                  oValid;
    logic                  iReady;
    logic                  oStart;
    logic                  oLast;
    logic                  oKey_loaded;
    logic                  oErr;

    modport slave (
        input  iEn, iLoad_key, iKey_data, iKey_valid, iMsg_data, iMsg_valid, iMsg_last, iReady,
        output oKey_ready, oMsg_ready, oData, oValid, oStart, oLast, oKey_loaded, oErr
    );

    modport master (
        output iEn, iLoad_key, iKey_data, iKey_valid, iMsg_data, iMsg_valid, iMsg_last, iReady,
        input  oKey_ready, oMsg_ready, oData, oValid, oStart, oLast, oKey_loaded, oErr
    );
endinterface

// File: rtl/xor_key_store.sv
// Key shift register with load counter and lane slice mux.
// XOR_KEY_ROTATE_EN adds a 1-bit left rotate per completed message.
module xor_key_store
    import xor_cipher_pkg::*;
#(
    parameter  int unsigned KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter  int unsigned LANE_WIDTH = DEF_LANE_WIDTH,
    localparam int unsigned K_BEATS    = beats(KEY_WIDTH, LANE_WIDTH),
    localparam int unsigned PTR_W      = clog2_safe(K_BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [LANE_WIDTH-1:0] shift_data,
`ifdef XOR_KEY_ROTATE_EN
    input  logic                  rotate,
`endif
    input  logic [PTR_W-1:0]      ptr,
    output logic [LANE_WIDTH-1:0] slice,
    output logic                  last_beat
);

    logic [KEY_WIDTH-1:0] key;
    logic [PTR_W-1:0]     cnt;

    assign last_beat = (cnt == PTR_W'(K_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key <= '0;
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (shift_en) begin
            key <= (key << LANE_WIDTH) | KEY_WIDTH'(shift_data);
            cnt <= last_beat ? '0 : cnt + PTR_W'(1);
        end
`ifdef XOR_KEY_ROTATE_EN
        else if (rotate) begin
            key <= (key << 1) | (key >> (KEY_WIDTH - 1));
        end
`endif
    end

    // Slice 0 is the most significant lane (first key beat loaded).
    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < K_BEATS; i++) begin
            if (ptr == PTR_W'(i)) slice = key[KEY_WIDTH-1-i*LANE_WIDTH -: LANE_WIDTH];
        end
    end

endmodule

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: cyclic key over LANE_WIDTH beats, single output register.
// XOR_KEY_ROTATE_EN rotates the key left by one bit after each message.
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int unsigned KEY_WIDTH    = DEF_KEY_WIDTH,
    parameter int unsigned LANE_WIDTH   = DEF_LANE_WIDTH,
    parameter int unsigned MAX_MSG_BITS = DEF_MAX_MSG_BITS
) (
    input logic                iClk,
    input logic                iRst,
    xor_stream_cipher_if.slave bus
);

    localparam int unsigned K_BEATS = beats(KEY_WIDTH, LANE_WIDTH);
    localparam int unsigned M_BEATS = beats(MAX_MSG_BITS, LANE_WIDTH);
    localparam int unsigned PTR_W   = clog2_safe(K_BEATS);
    localparam int unsigned CNT_W   = clog2_safe(M_BEATS);

    if (KEY_WIDTH % LANE_WIDTH != 0) begin : g_chk_key
        $error("KEY_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (MAX_MSG_BITS % LANE_WIDTH != 0) begin : g_chk_msg
        $error("MAX_MSG_BITS must be a multiple of LANE_WIDTH");
    end

    state_t                state, state_nxt;
    logic                  key_ready, msg_ready, key_take, msg_take;
    logic                  key_last_beat, key_done, msg_end, overflow;
    logic                  key_loaded, valid_q, start_q, last_q, err_q;
    logic [LANE_WIDTH-1:0] data_q, slice;
    logic [PTR_W-1:0]      ptr;
    logic [CNT_W-1:0]      beat_cnt;

    xor_key_store #(
        .KEY_WIDTH (KEY_WIDTH),
        .LANE_WIDTH(LANE_WIDTH)
    ) u_key (
        .clk       (iClk),
        .rst       (iRst),
        .clear     (bus.iEn && state == IDLE && bus.iLoad_key),
        .shift_en  (key_take),
        .shift_data(bus.iKey_data),
`ifdef XOR_KEY_ROTATE_EN
        .rotate    (bus.iEn && valid_q && last_q && bus.iReady),
`endif
        .ptr       (ptr),
        .slice     (slice),
        .last_beat (key_last_beat)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.iEn) begin
            unique case (state)
                IDLE:     if (bus.iLoad_key) state_nxt = LOAD_KEY;
                          else if (key_loaded && bus.iMsg_valid) state_nxt = STREAM;
                LOAD_KEY: if (!bus.iLoad_key || key_done) state_nxt = IDLE;
                STREAM:   if (msg_take && msg_end) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        key_ready = bus.iEn && state == LOAD_KEY;
        msg_ready = bus.iEn && state == STREAM && (!valid_q || bus.iReady);
        key_take  = key_ready && bus.iKey_valid;
        msg_take  = msg_ready && bus.iMsg_valid;
        key_done  = key_take && key_last_beat;
        overflow  = (beat_cnt == CNT_W'(M_BEATS - 1)) && !bus.iMsg_last;
        msg_end   = bus.iMsg_last || overflow;
    end

    // A beat completing the key while the load request has dropped is still an abort.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            key_loaded <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            ptr        <= '0;
            beat_cnt   <= '0;
        end else begin
            err_q <= 1'b0;
            if (bus.iEn) begin
                if (state == IDLE && bus.iLoad_key) key_loaded <= 1'b0;
                else if (key_done && bus.iLoad_key) key_loaded <= 1'b1;

                if (msg_take) begin
                    data_q  <= bus.iMsg_data ^ slice;
                    valid_q <= 1'b1;
                    start_q <= (beat_cnt == '0);
                    last_q  <= msg_end;
                    err_q   <= overflow;
                    if (msg_end) begin
                        ptr      <= '0;
                        beat_cnt <= '0;
                    end else begin
                        ptr      <= (ptr == PTR_W'(K_BEATS - 1)) ? '0 : ptr + PTR_W'(1);
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end else if (bus.iReady) begin
                    valid_q <= 1'b0;
                    start_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.oKey_ready  = key_ready;
    assign bus.oMsg_ready  = msg_ready;
    assign bus.oData       = data_q;
    assign bus.oValid      = valid_q;
    assign bus.oStart      = start_q;
    assign bus.oLast       = last_q;
    assign bus.oKey_loaded = key_loaded;
    assign bus.oErr        = err_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed bench for xor_stream_cipher (KEY=32, LANE=8, 512-bit messages).
module tb_xor_stream_cipher;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    always #5 iClk = ~iClk;

    xor_stream_cipher_if #(.LANE_WIDTH(8)) bus ();

    xor_stream_cipher #(
        .KEY_WIDTH   (32),
        .LANE_WIDTH  (8),
        .MAX_MSG_BITS(512)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] din;
        logic       last;
        logic [7:0] exp;
        logic       exp_start;
        logic       exp_last;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       start;
        logic       last;
        logic       err;
    } rx_t;

    vec_t        vecs[5];
    rx_t         rx_q[$];
    rx_t         prev_out;
    logic        stall_prev = 1'b0;
    bit          mon_bp = 1'b0;
    int unsigned err_pulses = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: collects transferred beats, checks stall stability.
    always @(negedge iClk) begin
        if (!iRst) begin
            if (bus.oErr) err_pulses++;
            if (mon_bp && stall_prev) begin
                chk1("bp_hold_valid", bus.oValid, 1'b1);
                chk8("bp_hold_data", bus.oData, prev_out.data);
                chk1("bp_hold_start", bus.oStart, prev_out.start);
                chk1("bp_hold_last", bus.oLast, prev_out.last);
            end
            if (mon_bp && bus.oValid && !bus.iReady)
                chk1("bp_msg_ready_low", bus.oMsg_ready, 1'b0);
            if (bus.oValid && bus.iReady && bus.iEn)
                rx_q.push_back('{data: bus.oData, start: bus.oStart, last: bus.oLast, err: bus.oErr});
            stall_prev = bus.oValid && !bus.iReady;
            prev_out   = '{data: bus.oData, start: bus.oStart, last: bus.oLast, err: bus.oErr};
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int unsigned t = 0;
        bus.iMsg_data  = d;
        bus.iMsg_last  = l;
        bus.iMsg_valid = 1'b1;
        @(negedge iClk);
        while (!bus.oMsg_ready && t < 50) begin
            @(negedge iClk);
            t++;
        end
        if (t >= 50) chk1("msg_ready_timeout", bus.oMsg_ready, 1'b1);
        @(posedge iClk);
        #1;
        bus.iMsg_valid = 1'b0;
        bus.iMsg_last  = 1'b0;
    endtask

    task automatic key_beat(input logic [7:0] d);
        int unsigned t = 0;
        bus.iKey_data  = d;
        bus.iKey_valid = 1'b1;
        @(negedge iClk);
        while (!bus.oKey_ready && t < 50) begin
            @(negedge iClk);
            t++;
        end
        if (t >= 50) chk1("key_ready_timeout", bus.oKey_ready, 1'b1);
        @(posedge iClk);
        #1;
        bus.iKey_valid = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] k);
        bus.iLoad_key = 1'b1;
        for (int i = 0; i < 4; i++) key_beat(k[31-8*i -: 8]);
        bus.iLoad_key = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp2[4];
        logic [7:0]  key_bytes[4];
        logic [7:0]  exp64;
        bit          pat[4];
        int unsigned seen_ready, seen_valid;

        bus.iEn = 1'b1;  bus.iLoad_key = 1'b0;  bus.iKey_data = '0;  bus.iKey_valid = 1'b0;
        bus.iMsg_data = '0;  bus.iMsg_valid = 1'b0;  bus.iMsg_last = 1'b0;  bus.iReady = 1'b1;

`ifdef XOR_KEY_ROTATE_EN
        exp2  = '{8'hBD, 8'h5B, 8'h7D, 8'hDF};
        exp64 = 8'hBD;
`else
        exp2  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp64 = 8'hDE;
`endif
        key_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pat       = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[0] = '{din: 8'h00, last: 1'b0, exp: 8'hDE, exp_start: 1'b1, exp_last: 1'b0};
        vecs[1] = '{din: 8'h11, last: 1'b0, exp: 8'hBC, exp_start: 1'b0, exp_last: 1'b0};
        vecs[2] = '{din: 8'h22, last: 1'b0, exp: 8'h9C, exp_start: 1'b0, exp_last: 1'b0};
        vecs[3] = '{din: 8'h33, last: 1'b0, exp: 8'hDC, exp_start: 1'b0, exp_last: 1'b0};
        vecs[4] = '{din: 8'h44, last: 1'b1, exp: 8'h9A, exp_start: 1'b0, exp_last: 1'b1};

        // Reset state
        step(2);
        chk1("rst_valid", bus.oValid, 1'b0);
        chk8("rst_data", bus.oData, 8'h00);
        chk1("rst_key_loaded", bus.oKey_loaded, 1'b0);
        chk1("rst_key_ready", bus.oKey_ready, 1'b0);
        chk1("rst_msg_ready", bus.oMsg_ready, 1'b0);
        chk1("rst_err", bus.oErr, 1'b0);
        iRst = 1'b0;
        step(1);

        // Basic stream: one-cycle latency checked right after each accept edge
        load_key(32'hDEADBEEF);
        chk1("key_loaded", bus.oKey_loaded, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_beat(vecs[i].din, vecs[i].last);
            chk1("basic_valid", bus.oValid, 1'b1);
            chk8("basic_data", bus.oData, vecs[i].exp);
            chk1("basic_start", bus.oStart, vecs[i].exp_start);
            chk1("basic_last", bus.oLast, vecs[i].exp_last);
        end

        // Second message of zeros exposes the keystream for message 2
        for (int i = 0; i < 4; i++) begin
            send_beat(8'h00, i == 3);
            chk8("msg2_data", bus.oData, exp2[i]);
        end
        step(3);

        // Backpressure with iReady pattern 1,0,0,1
        load_key(32'hDEADBEEF);
        rx_q.delete();
        mon_bp = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) send_beat(vecs[i].din, vecs[i].last);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    bus.iReady = pat[k % 4];
                    @(posedge iClk);
                    #1;
                end
                bus.iReady = 1'b1;
            end
        join
        mon_bp = 1'b0;
        chki("bp_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                chk8("bp_data", rx_q[i].data, vecs[i].exp);
                chk1("bp_start", rx_q[i].start, vecs[i].exp_start);
                chk1("bp_last", rx_q[i].last, vecs[i].exp_last);
            end
        end

        // Overflow: 64 beats without last, then a 65th beat opens a new message
        load_key(32'hDEADBEEF);
        rx_q.delete();
        err_pulses = 0;
        for (int i = 0; i < 65; i++) send_beat(8'h00, i == 64);
        step(3);
        chki("ovf_count", rx_q.size(), 65);
        if (rx_q.size() >= 65) begin
            chk1("ovf_first_start", rx_q[0].start, 1'b1);
            chk8("ovf_beat62_data", rx_q[62].data, key_bytes[62 % 4]);
            chk1("ovf_beat62_last", rx_q[62].last, 1'b0);
            chk8("ovf_beat63_data", rx_q[63].data, key_bytes[63 % 4]);
            chk1("ovf_beat63_last", rx_q[63].last, 1'b1);
            chk1("ovf_beat63_err", rx_q[63].err, 1'b1);
            chk1("ovf_beat64_start", rx_q[64].start, 1'b1);
            chk8("ovf_beat64_data", rx_q[64].data, exp64);
        end
        chki("ovf_err_pulses", err_pulses, 1);

        // Aborted key load
        bus.iLoad_key = 1'b1;
        key_beat(8'h11);
        key_beat(8'h22);
        bus.iLoad_key = 1'b0;
        step(2);
        chk1("abort_key_loaded", bus.oKey_loaded, 1'b0);
        bus.iMsg_valid = 1'b1;
        seen_ready = 0;
        seen_valid = 0;
        repeat (10) begin
            @(negedge iClk);
            if (bus.oMsg_ready) seen_ready++;
            if (bus.oValid) seen_valid++;
        end
        chki("abort_msg_ready_cycles", seen_ready, 0);
        chki("abort_valid_cycles", seen_valid, 0);
        bus.iMsg_valid = 1'b0;
        step(1);

        // Asynchronous reset mid-stream
        load_key(32'hDEADBEEF);
        send_beat(8'h00, 1'b0);
        send_beat(8'h11, 1'b0);
        chk8("rst_mid_pre_data", bus.oData, 8'hBC);
        bus.iMsg_data  = 8'h22;
        bus.iMsg_valid = 1'b1;
        #3;
        iRst = 1'b1;
        #1;
        chk1("rst_mid_valid", bus.oValid, 1'b0);
        chk8("rst_mid_data", bus.oData, 8'h00);
        chk1("rst_mid_start", bus.oStart, 1'b0);
        chk1("rst_mid_last", bus.oLast, 1'b0);
        chk1("rst_mid_key_loaded", bus.oKey_loaded, 1'b0);
        chk1("rst_mid_msg_ready", bus.oMsg_ready, 1'b0);
        step(1);
        iRst = 1'b0;
        seen_ready = 0;
        seen_valid = 0;
        repeat (10) begin
            @(negedge iClk);
            if (bus.oMsg_ready) seen_ready++;
            if (bus.oValid) seen_valid++;
        end
        chki("rst_after_msg_ready_cycles", seen_ready, 0);
        chki("rst_after_valid_cycles", seen_valid, 0);
        bus.iMsg_valid = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
